uart_rx_ctl: RTL

UART_RX_CTL -- requirements
Module: uart_rx_ctl

---
 rtl/uart_rx_ctl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctl.sv
// UART receiver (8N1, LSB first) with an oversampling front end and a byte FIFO.
// The line is synchronized, a start is detected on a falling edge at bclk ticks, and
// each bit is sampled once near its centre. Good bytes go to a circular FIFO that the
// consumer pops with rd. Status flags are registered from the post-update count.
module uart_rx_ctl #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned OVS        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bclk,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned PtrW   = DEPTH_LOG2;
  localparam int unsigned CountW = DEPTH_LOG2 + 1;
  localparam int unsigned CntW   = $clog2(OVS);

  localparam logic [CntW-1:0]   HalfLast = CntW'(OVS / 2 - 1);
  localparam logic [CntW-1:0]   BitLast  = CntW'(OVS - 1);
  localparam logic [CountW-1:0] DepthCnt = CountW'(Depth);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Line front end
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       prev_q, prev_d;
  logic       rxs;
  logic       start_edge;

  // Receiver FSM
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            stop_tick;

  // FIFO and outputs
  logic [7:0]        mem_q [Depth];
  logic [7:0]        mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic [7:0]        dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              pop;
  logic              push;
  logic              fifo_ok;

  assign rxs = sync2_q;

  // fill_q marks when both sync stages hold real line samples rather than reset values;
  // armed_q then requires the line to be seen high before any start is honoured, so a
  // line held low through reset cannot fake a start edge.
  assign start_edge = prev_q & ~rxs & armed_q;

  // Synchronizer, previous-tick sample and start arming
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    prev_d  = prev_q;
    armed_d = armed_q;
    if (bclk) begin
      prev_d = rxs;
      if (rxs && fill_q[1]) begin
        armed_d = 1'b1;
      end
    end
  end

  // Receiver next-state: start qualification, data sampling, stop sampling
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_tick = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bclk && start_edge) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (bclk) begin
          if (cnt_q == HalfLast) begin
            cnt_d   = '0;
            bit_d   = '0;
            // A high line at mid-start is a glitch, not a frame.
            state_d = rxs ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (bclk) begin
          if (cnt_q == BitLast) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (bclk) begin
          if (cnt_q == BitLast) begin
            cnt_d     = '0;
            stop_tick = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign pop     = rd & ~empty_q;
  // A full FIFO still takes the byte when a pop frees a slot on the same edge.
  assign fifo_ok = (count_q < DepthCnt) | pop;
  assign push    = stop_tick & rxs & fifo_ok;

  // FIFO pointers, count, flags and output registers
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    frame_err_d = stop_tick & ~rxs;
    overrun_d   = stop_tick & rxs & ~fifo_ok;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      dout_d     = mem_q[rd_ptr_q];
      dout_vld_d = 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountW'(1);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DepthCnt);
  end

  // FIFO storage write port
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      prev_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // FIFO storage; contents are only read after being written, so no reset is needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout      = dout_q;
  assign dout_vld  = dout_vld_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
